// File: rtl/axis_video_tx.sv
// Pixel-to-AXI4-Stream video transmitter: a 2-entry skid FIFO feeding a registered
// stream port, with start-of-frame (TUSER) and end-of-line (TLAST) generation.
module axis_video_tx #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [23:0] rgb_in,
   input  logic        rgb_valid,
   output logic        datapath_ready,
   output logic [31:0] TDATA,
   output logic        TVALID,
   input  logic        TREADY,
   output logic        TUSER,
   output logic        TLAST,
   output logic        frame_done,
   output logic        busy
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [1:0]    r_count;
   logic [1:0]    w_count_nxt;
   logic [23:0]   r_head;
   logic [23:0]   r_tail;
   logic [23:0]   w_head_nxt;
   logic [23:0]   w_tail_nxt;
   logic [CW-1:0] r_col;
   logic [CW-1:0] w_col_nxt;
   logic [RW-1:0] r_row;
   logic [RW-1:0] w_row_nxt;

   logic          r_ready;
   logic          r_tvalid;
   logic          r_tuser;
   logic          r_tlast;
   logic          r_frame_done;
   logic          r_busy;

   logic          w_ready_nxt;
   logic          w_tvalid_nxt;
   logic          w_tuser_nxt;
   logic          w_tlast_nxt;
   logic          w_busy_nxt;

   logic          w_accept;
   logic          w_xfer;
   logic          w_col_last;
   logic          w_row_last;
   logic          w_frame_end;

   // r_ready/r_tvalid are registered copies of (count<2)/(count>0), so neither
   // handshake side sees a combinational path from the other.
   assign w_accept    = rgb_valid & r_ready;
   assign w_xfer      = r_tvalid & TREADY;
   assign w_col_last  = (r_col == COL_LAST);
   assign w_row_last  = (r_row == ROW_LAST);
   assign w_frame_end = w_xfer & w_col_last & w_row_last;

   assign datapath_ready = r_ready;
   assign TDATA          = {8'h00, r_head};
   assign TVALID         = r_tvalid;
   assign TUSER          = r_tuser;
   assign TLAST          = r_tlast;
   assign frame_done     = r_frame_done;
   assign busy           = r_busy;

   // Frame state register.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Frame state transitions: enter on the start-of-frame beat, leave on the final beat.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_xfer && (r_col == {CW{1'b0}}) && (r_row == {RW{1'b0}})) begin
               w_state_nxt = S_ACTIVE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ACTIVE: begin
            if (w_frame_end) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_ACTIVE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FIFO occupancy and storage; the head entry is what TDATA presents.
   always_comb begin
      w_count_nxt = r_count;
      w_head_nxt  = r_head;
      w_tail_nxt  = r_tail;
      case ({w_accept, w_xfer})
         2'b10: begin
            w_count_nxt = r_count + 2'd1;
            if (r_count == 2'd0) begin
               w_head_nxt = rgb_in;
            end else begin
               w_tail_nxt = rgb_in;
            end
         end
         2'b01: begin
            w_count_nxt = r_count - 2'd1;
            w_head_nxt  = r_tail;
         end
         2'b11: begin
            w_count_nxt = r_count;
            if (r_count == 2'd1) begin
               w_head_nxt = rgb_in;
            end else begin
               w_head_nxt = r_tail;
               w_tail_nxt = rgb_in;
            end
         end
         default: begin
            w_count_nxt = r_count;
         end
      endcase
   end

   // Beat position within the frame, advanced only by stream transfers.
   always_comb begin
      w_col_nxt = r_col;
      w_row_nxt = r_row;
      if (w_xfer) begin
         if (w_col_last) begin
            w_col_nxt = {CW{1'b0}};
            if (w_row_last) begin
               w_row_nxt = {RW{1'b0}};
            end else begin
               w_row_nxt = r_row + {{(RW-1){1'b0}}, 1'b1};
            end
         end else begin
            w_col_nxt = r_col + {{(CW-1){1'b0}}, 1'b1};
            w_row_nxt = r_row;
         end
      end else begin
         w_col_nxt = r_col;
         w_row_nxt = r_row;
      end
   end

   // Next values of the registered outputs, derived from next-cycle state.
   always_comb begin
      w_ready_nxt  = (w_count_nxt != 2'd2);
      w_tvalid_nxt = (w_count_nxt != 2'd0);
      w_tuser_nxt  = w_tvalid_nxt && (w_col_nxt == {CW{1'b0}}) && (w_row_nxt == {RW{1'b0}});
      w_tlast_nxt  = w_tvalid_nxt && (w_col_nxt == COL_LAST);
      w_busy_nxt   = (w_state_nxt == S_ACTIVE) || (w_count_nxt != 2'd0);
   end

   // Datapath, counters and output registers.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_count      <= 2'd0;
         r_head       <= 24'h000000;
         r_tail       <= 24'h000000;
         r_col        <= {CW{1'b0}};
         r_row        <= {RW{1'b0}};
         r_ready      <= 1'b0;
         r_tvalid     <= 1'b0;
         r_tuser      <= 1'b0;
         r_tlast      <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_count      <= w_count_nxt;
         r_head       <= w_head_nxt;
         r_tail       <= w_tail_nxt;
         r_col        <= w_col_nxt;
         r_row        <= w_row_nxt;
         r_ready      <= w_ready_nxt;
         r_tvalid     <= w_tvalid_nxt;
         r_tuser      <= w_tuser_nxt;
         r_tlast      <= w_tlast_nxt;
         r_frame_done <= w_frame_end;
         r_busy       <= w_busy_nxt;
      end
   end

endmodule

// File: tb/tb_axis_video_tx.sv
// Randomized scoreboard bench for axis_video_tx (4x2 frames): accepted pixels are
// queued by the driver, a negedge monitor checks every beat against a frame-position model.
module tb_axis_video_tx;

   localparam int W     = 4;
   localparam int H     = 2;
   localparam int FRAME = W * H;

   logic        clk = 1'b0;
   logic        resetN;
   logic [23:0] rgb_in;
   logic        rgb_valid;
   logic        datapath_ready;
   logic [31:0] TDATA;
   logic        TVALID;
   logic        TREADY;
   logic        TUSER;
   logic        TLAST;
   logic        frame_done;
   logic        busy;

   axis_video_tx #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .resetN(resetN), .rgb_in(rgb_in), .rgb_valid(rgb_valid),
      .datapath_ready(datapath_ready), .TDATA(TDATA), .TVALID(TVALID), .TREADY(TREADY),
      .TUSER(TUSER), .TLAST(TLAST), .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [23:0] exp_q[$];
   int          m_count  = 0;
   int          m_beats  = 0;
   int          m_pulses = 0;
   bit          m_done_exp = 1'b0;
   bit          rst_edge = 1'b0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic        prev_user;
   logic        prev_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Remembers whether the DUT saw reset at the most recent clock edge.
   always @(posedge clk) rst_edge <= !resetN;

   // Output monitor: pops the scoreboard on every transfer.
   always @(negedge clk) begin
      if (rst_edge) begin
         chk("reset_ctrl", 32'({datapath_ready, TVALID, TUSER, TLAST, frame_done, busy}), 32'd0);
         chk("reset_tdata", TDATA, 32'h0);
         m_count = 0; m_beats = 0; m_done_exp = 1'b0; prev_stall = 1'b0;
      end else begin
         chk("ready", 32'(datapath_ready), 32'(m_count < 2));
         chk("tvalid", 32'(TVALID), 32'(m_count > 0));
         chk("busy", 32'(busy), 32'(((m_beats % FRAME) != 0) || (m_count > 0)));
         chk("frame_done", 32'(frame_done), 32'(m_done_exp));
         if (frame_done) m_pulses++;
         chk("tuser", 32'(TUSER), 32'(TVALID && ((m_beats % FRAME) == 0)));
         chk("tlast", 32'(TLAST), 32'(TVALID && ((m_beats % W) == W - 1)));
         if (prev_stall) begin
            chk("stall_tvalid", 32'(TVALID), 32'd1);
            chk("stall_tdata", TDATA, prev_data);
            chk("stall_marks", 32'({TUSER, TLAST}), 32'({prev_user, prev_last}));
         end
         m_done_exp = 1'b0;
         if (TVALID && TREADY) begin
            if (exp_q.size() == 0) begin
               chk("underflow", 32'(exp_q.size()), 32'd1);
            end else begin
               chk("tdata", TDATA, {8'h00, exp_q.pop_front()});
            end
            m_beats++;
            if ((m_beats % FRAME) == 0) m_done_exp = 1'b1;
            m_count--;
         end
         if (rgb_valid && datapath_ready) m_count++;
         prev_stall = TVALID && !TREADY;
         prev_data  = TDATA;
         prev_user  = TUSER;
         prev_last  = TLAST;
      end
   end

   // One stimulus cycle; a pixel is queued when the DUT will accept it at the next edge.
   task automatic cyc(input logic v, input logic [23:0] pix, input logic tr, output bit acc);
      @(posedge clk);
      #1;
      rgb_valid = v;
      rgb_in    = pix;
      TREADY    = tr;
      acc       = v && datapath_ready;
      if (acc) exp_q.push_back(pix);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      resetN = 1'b0; rgb_valid = 1'b0; TREADY = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      resetN = 1'b1;
   endtask

   task automatic drain(input int budget);
      bit acc;
      for (int i = 0; i < budget && (exp_q.size() != 0 || m_count != 0); i++) cyc(1'b0, 24'h0, 1'b1, acc);
      repeat (3) cyc(1'b0, 24'h0, 1'b1, acc);
      chk("drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acc;
      int          n;
      int          p0;
      logic [23:0] pix;
      resetN = 1'b0; rgb_valid = 1'b0; TREADY = 1'b0; rgb_in = 24'h0;
      do_reset();

      // Basic: 8 consecutive pixels into an always-ready sink.
      p0 = m_pulses; pix = 24'd1;
      for (int i = 0; i < 40 && pix <= 24'd8; i++) begin
         cyc(1'b1, pix, 1'b1, acc);
         if (acc) pix++;
      end
      drain(50);
      chk("basic_frames", 32'(m_pulses - p0), 32'd1);

      // Backpressure: sink stalled, three pixels offered.
      n = 0; pix = 24'd1;
      for (int i = 0; i < 6; i++) begin
         cyc(pix <= 24'd3, pix, 1'b0, acc);
         if (acc) begin n++; pix++; end
      end
      chk("bp_accepted", 32'(n), 32'd2);
      chk("bp_head", TDATA, 32'h1);
      for (int i = 0; i < 20 && pix <= 24'd3; i++) begin
         cyc(1'b1, pix, 1'b1, acc);
         if (acc) pix++;
      end
      drain(50);

      // Toggled handshakes over two full frames.
      do_reset();
      p0 = m_pulses; n = 0;
      for (int c = 0; c < 400 && n < 2 * FRAME; c++) begin
         cyc(((c / 4) % 2) == 0, 24'(24'h100 + n), ((c / 8) % 2) == 1, acc);
         if (acc) n++;
      end
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) cyc(1'b0, 24'h0, ((c / 8) % 2) == 0, acc);
      drain(50);
      chk("toggle_frames", 32'(m_pulses - p0), 32'd2);

      // Simultaneous push and pop at steady occupancy of one.
      for (int i = 0; i < 12; i++) cyc(1'b1, 24'(24'h200 + i), 1'b1, acc);
      drain(50);

      // Reset after the third beat of a frame, then resume.
      do_reset();
      pix = 24'h300;
      for (int i = 0; i < 40 && m_beats < 3; i++) begin
         cyc(1'b1, pix, 1'b1, acc);
         if (acc) pix++;
      end
      do_reset();
      for (int i = 0; i < 6; i++) cyc(1'b1, 24'(24'h400 + i), 1'b1, acc);
      drain(50);

      // Random traffic with random stalls.
      for (int i = 0; i < 800; i++) cyc(1'($urandom_range(0, 1)), 24'($urandom), ($urandom % 4) != 0, acc);
      drain(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_video_tx.md
AXIS_VIDEO_TX -- requirements
Module: axis_video_tx

Parameters
REQ-001 The block SHALL have parameter IMG_WIDTH, default 640, meaning pixels per line (at least 2).
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 480, meaning lines per frame (at least 1).

Interface
REQ-003 Port clk, input, 1 bit: clock; all logic SHALL be rising-edge.
REQ-004 Port resetN, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port rgb_in, input, 24 bits: pixel from datapath, RGB_t packing {R,G,B}.
REQ-006 Port rgb_valid, input, 1 bit: rgb_in valid this cycle.
REQ-007 Port datapath_ready, output, 1 bit: block can accept a pixel this cycle.
REQ-008 Port TDATA, output, 32 bits: stream data (FDATA).
REQ-009 Port TVALID, output, 1 bit: AXI4-Stream valid.
REQ-010 Port TREADY, input, 1 bit: AXI4-Stream ready from the receiver.
REQ-011 Port TUSER, output, 1 bit: start-of-frame marker.
REQ-012 Port TLAST, output, 1 bit: end-of-line marker.
REQ-013 Port frame_done, output, 1 bit: one-cycle pulse after the last beat of a frame.
REQ-014 Port busy, output, 1 bit: frame in progress or buffer non-empty.

Function
REQ-015 Input accept SHALL occur when rgb_valid and datapath_ready are both 1 at a rising edge.
REQ-016 Stream transfer SHALL occur when TVALID and TREADY are both 1 at a rising edge.
REQ-017 Buffering SHALL use a 2-entry FIFO (count 0..2) between the accept and transfer sides, with all outputs registered.
REQ-018 datapath_ready SHALL equal (count < 2) and SHALL NOT depend combinationally on TREADY.
REQ-019 TVALID SHALL equal (count > 0).
REQ-020 TDATA SHALL equal {8'h00, head pixel}.
REQ-021 Latency: a pixel accepted at edge N SHALL be presented on TDATA/TVALID after edge N, i.e. minimum 1 cycle.
REQ-022 Count update per cycle:
- accept only: +1
- transfer only: -1
- both: unchanged
- FIFO order SHALL be preserved in all three cases.
REQ-023 With count = 2, rgb_valid SHALL be ignored; no overwrite and no pixel loss.
REQ-024 While TVALID = 1 and TREADY = 0, TDATA, TUSER and TLAST SHALL hold stable.
REQ-025 TVALID SHALL NOT deassert until a transfer occurs.
REQ-026 Beat counters: col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) SHALL advance only on a transfer.
- col wraps to 0 at IMG_WIDTH-1 and increments row.
- row wraps to 0 at IMG_HEIGHT-1.
REQ-027 TUSER SHALL be 1 exactly when col = 0, row = 0 and TVALID = 1.
REQ-028 TLAST SHALL be 1 exactly when col = IMG_WIDTH-1 and TVALID = 1.
REQ-029 The FSM SHALL have two states, IDLE and ACTIVE:
- IDLE -> ACTIVE on the first transfer of a frame (the TUSER beat).
- ACTIVE -> IDLE on the transfer with col = IMG_WIDTH-1 and row = IMG_HEIGHT-1.
REQ-030 frame_done SHALL be 1 for exactly the cycle following the final-beat transfer.
REQ-031 Back-to-back frames SHALL NOT require idle cycles; the next frame's TUSER beat SHALL be allowed in the cycle after the final beat.
REQ-032 busy SHALL equal (state = ACTIVE) or (count > 0).
REQ-033 IMG_HEIGHT = 1: TUSER and TLAST SHALL appear on separate beats, and every TLAST beat SHALL also end the frame.

Reset
REQ-034 With resetN = 0 at an edge, the block SHALL clear:
- count = 0, col = 0, row = 0, state = IDLE
- TVALID = 0, TUSER = 0, TLAST = 0, frame_done = 0, busy = 0
- TDATA = 32'h0
- datapath_ready = 0 during reset, 1 in the first cycle after release.
REQ-035 Reset mid-frame SHALL discard buffered pixels and restart counting, so the first post-reset transfer carries TUSER = 1.

Verification
REQ-036 Basic, IMG_WIDTH = 4, IMG_HEIGHT = 2, TREADY = 1, 8 consecutive pixels 0x000001..0x000008:
- TDATA 0x00000001..0x00000008 on 8 consecutive cycles starting 1 cycle after the first accept.
- TUSER on beat 1, TLAST on beats 4 and 8, frame_done 1 cycle after beat 8.
REQ-037 Backpressure, TREADY = 0 with 3 pixels offered:
- Only 2 accepted; datapath_ready = 0 with count = 2.
- TDATA stays 0x00000001 until TREADY = 1.
- No pixel lost; order 1, 2, 3.
REQ-038 Toggling handshakes, rgb_valid toggled every 4 cycles and TREADY every 8 cycles over 2 frames:
- Output beat sequence equals input order.
- Exactly 2 frame_done pulses; TLAST every 4th beat.
REQ-039 Simultaneous push/pop at count = 1 for 10 cycles: count stays 1 and output order is intact.
REQ-040 Reset after beat 3 of a frame:
- All outputs at reset values.
- Next first beat carries TUSER = 1 with col = 0.
REQ-041 Stability check, random TREADY stalls: TDATA, TUSER and TLAST never change while TVALID = 1 and TREADY = 0.
